// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider producing {remainder, quotient}
// for the HI/LO write path; holds the pipeline via stall_div until ready.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic               annul,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               stall_div
);
   typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
   state_t state, next;
   logic sgn, s1, s2;
   logic [WIDTH-1:0] dvs, quo, rem, a_abs, b_abs, q_fix, r_fix;
   logic [WIDTH:0] trial;
   logic [5:0] cnt;
   logic accept, last;
   always_comb begin
      accept = start & ~annul;
      last = cnt == 6'(WIDTH);
      a_abs = (signed_div & opdata1[WIDTH-1]) ? -opdata1 : opdata1;
      b_abs = (signed_div & opdata2[WIDTH-1]) ? -opdata2 : opdata2;
      // the pre-shift remainder is always below the divisor, so WIDTH bits hold it
      trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
      q_fix = (sgn & (s1 ^ s2)) ? -quo : quo;
      r_fix = (sgn & s1) ? -rem : rem;
      ready = state == END;
      stall_div = start & ~ready;
   end
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = accept ? ((opdata2 == '0) ? BYZERO : ON) : IDLE;
         BYZERO:  next = END;
         ON:      next = annul ? IDLE : (last ? END : ON);
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sgn    <= 1'b0;
         s1     <= 1'b0;
         s2     <= 1'b0;
         dvs    <= '0;
         quo    <= '0;
         rem    <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         state <= next;
         case (state)
            IDLE: if (accept) begin
               sgn <= signed_div;
               s1  <= opdata1[WIDTH-1];
               s2  <= opdata2[WIDTH-1];
               quo <= a_abs;
               dvs <= b_abs;
               rem <= '0;
               cnt <= '0;
            end
            BYZERO: result <= '0;
            ON: if (annul) cnt <= '0;
               else if (last) result <= {r_fix, q_fix};
               else begin
                  rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                  cnt <= cnt + 6'd1;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vector table plus hand-written annul, reset and back-to-back
// sequences for div_iter.
module tb_div_iter;
   logic clk = 0, rst = 0, start = 0, signed_div = 0, annul = 0;
   logic [31:0] opdata1 = 0, opdata2 = 0;
   logic [63:0] result;
   logic ready, stall_div;
   int total = 0, bad = 0;

   div_iter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
      .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready),
      .stall_div(stall_div)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sd;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive an operation and count edges until ready (bounded), plus stall cycles seen.
   task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls);
      signed_div = sd;
      opdata1 = a;
      opdata2 = b;
      start = 1;
      #1;
      lat = 0;
      stalls = 0;
      do begin
         stalls += int'(stall_div);
         tick();
         lat++;
      end while (!ready && lat < 100);
   endtask

   vec_t v[9];
   int lat, stalls;
   logic [63:0] held;

   initial begin
      v[0] = '{1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34};
      v[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34};
      v[2] = '{1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 34};
      v[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34};
      v[4] = '{1'b0, 32'd5, 32'd0, 64'h0, 2};
      v[5] = '{1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 34};
      v[6] = '{1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 34};
      v[7] = '{1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 34};
      v[8] = '{1'b1, 32'd7, 32'd0, 64'h0, 2};

      rst = 1;
      tick();
      tick();
      rst = 0;
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_result", result, 64'd0);
      chk("reset_stall", 64'(stall_div), 64'd0);

      foreach (v[i]) begin
         run_div(v[i].sd, v[i].a, v[i].b, lat, stalls);
         chk($sformatf("vec%0d_result", i), result, v[i].exp);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(v[i].lat));
         chk($sformatf("vec%0d_stall", i), 64'(stalls), 64'(v[i].lat));
         chk($sformatf("vec%0d_stall_at_ready", i), 64'(stall_div), 64'd0);
         start = 0;
         tick();
         chk($sformatf("vec%0d_ready_drop", i), 64'(ready), 64'd0);
         chk($sformatf("vec%0d_result_hold", i), result, v[i].exp);
      end

      // annul mid-operation with operand changes after acceptance
      held = result;
      signed_div = 0;
      opdata1 = 32'd1000;
      opdata2 = 32'd3;
      start = 1;
      stalls = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 5) begin
            opdata1 = 32'd77;
            opdata2 = 32'd0;
         end
         tick();
         stalls += int'(ready);
      end
      annul = 1;
      tick();
      stalls += int'(ready);
      annul = 0;
      start = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         stalls += int'(ready);
      end
      chk("annul_no_ready", 64'(stalls), 64'd0);
      chk("annul_result_held", result, held);
      run_div(1'b0, 32'd9, 32'd4, lat, stalls);
      chk("after_annul_result", result, 64'h00000001_00000002);
      chk("after_annul_latency", 64'(lat), 64'd34);
      start = 0;
      tick();

      // back-to-back with start held across END
      run_div(1'b0, 32'd50, 32'd5, lat, stalls);
      chk("b2b_first_result", result, 64'h00000000_0000000A);
      chk("b2b_first_latency", 64'(lat), 64'd34);
      run_div(1'b0, 32'd50, 32'd6, lat, stalls);
      chk("b2b_second_result", result, 64'h00000002_00000008);
      chk("b2b_second_latency", 64'(lat), 64'd35);
      chk("b2b_second_stall", 64'(stalls), 64'd34);
      start = 0;
      tick();

      // synchronous reset mid-operation
      signed_div = 1;
      opdata1 = 32'hFFFFFF00;
      opdata2 = 32'd3;
      start = 1;
      for (int c = 0; c < 15; c++) tick();
      rst = 1;
      tick();
      rst = 0;
      start = 0;
      #1;
      chk("midrst_ready", 64'(ready), 64'd0);
      chk("midrst_result", result, 64'd0);
      run_div(1'b0, 32'hFFFFFFFF, 32'h10, lat, stalls);
      chk("after_rst_result", result, 64'h0000000F_0FFFFFFF);
      chk("after_rst_latency", 64'(lat), 64'd34);
      start = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
